// File: rtl/multi_step_gen.sv
// Multi-channel step pulse generator fed by a one-deep segment shadow buffer.
// Latency: first step of a channel lands dt cycles after promotion; back-to-back segments promote with no gap.
// Backpressure: seg_ready is low while the shadow holds a segment; it reopens the cycle after promotion.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   seg_dt, seg_steps   per-channel interval / step count, channel i at [i*W +: W]
//   seg_valid/seg_ready segment handshake into the shadow buffer
//   abort_dt            WAIT timeout and ABORT step interval (0 behaves as 1), sampled live
//   stop                return to IDLE, discard the shadow and any offered segment
//   step_stb            one-cycle step pulse per channel
//   steps_done          steps emitted per channel in the current segment or abort run
//   seg_done            one-cycle pulse when the active segment completes
//   busy, abort         state != IDLE, and the abort indication
module multi_step_gen #(
    parameter int N_CH = 3,
    parameter int W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH*W-1:0] seg_dt,
    input  logic [N_CH*W-1:0] seg_steps,
    input  logic              seg_valid,
    output logic              seg_ready,
    input  logic [W-1:0]      abort_dt,
    input  logic              stop,
    output logic [N_CH-1:0]   step_stb,
    output logic [N_CH*W-1:0] steps_done,
    output logic              seg_done,
    output logic              busy,
    output logic              abort
);

    typedef logic [W-1:0] word_t;
    typedef logic [W:0]   wide_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    // Registered state
    state_t          r_state;
    logic            r_sh_full;
    word_t           r_sh_dt    [N_CH];
    word_t           r_sh_steps [N_CH];
    word_t           r_dt       [N_CH];
    word_t           r_steps    [N_CH];
    word_t           r_cnt      [N_CH];
    word_t           r_done     [N_CH];
    logic [N_CH-1:0] r_mask;        // channels that were active in the last promoted segment
    word_t           r_wait_cnt;
    word_t           r_abort_cnt;

    // Next-state values
    state_t          w_state_nxt;
    logic            w_sh_full_nxt;
    word_t           w_sh_dt_nxt    [N_CH];
    word_t           w_sh_steps_nxt [N_CH];
    word_t           w_dt_nxt       [N_CH];
    word_t           w_steps_nxt    [N_CH];
    word_t           w_cnt_nxt      [N_CH];
    word_t           w_done_nxt     [N_CH];
    logic [N_CH-1:0] w_mask_nxt;
    word_t           w_wait_nxt;
    word_t           w_acnt_nxt;

    // Combinational helpers and outputs
    logic [N_CH-1:0] w_ch_act;
    logic [N_CH-1:0] w_ch_hit;
    logic [N_CH-1:0] w_stb;
    logic            w_seg_end;
    logic            w_seg_done;
    logic            w_abort;
    logic            w_accept;
    logic            w_promote;
    word_t           w_adt;

    // True when a counter at cnt reaches its limit this cycle (cnt+1 >= lim),
    // evaluated one bit wider so an all-ones count cannot wrap.
    function automatic logic reached(input word_t cnt, input word_t lim);
        return (wide_t'(cnt) + wide_t'(1)) >= wide_t'(lim);
    endfunction

    always_comb begin
        w_state_nxt    = r_state;
        w_sh_full_nxt  = r_sh_full;
        w_sh_dt_nxt    = r_sh_dt;
        w_sh_steps_nxt = r_sh_steps;
        w_dt_nxt       = r_dt;
        w_steps_nxt    = r_steps;
        w_cnt_nxt      = r_cnt;
        w_done_nxt     = r_done;
        w_mask_nxt     = r_mask;
        w_wait_nxt     = r_wait_cnt;
        w_acnt_nxt     = r_abort_cnt;
        w_stb          = '0;
        w_seg_done     = 1'b0;
        w_abort        = (r_state == ST_ABORT);
        w_promote      = 1'b0;
        w_accept       = seg_valid && !r_sh_full;
        w_adt          = (abort_dt == '0) ? word_t'(1) : abort_dt;

        // A segment ends when every channel is either idle already or
        // emits its final step in this cycle.
        w_seg_end = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            w_ch_act[i] = (r_dt[i] != '0) && (r_done[i] < r_steps[i]);
            w_ch_hit[i] = w_ch_act[i] && reached(r_cnt[i], r_dt[i]);
            if (w_ch_act[i] && !(w_ch_hit[i] && reached(r_done[i], r_steps[i]))) begin
                w_seg_end = 1'b0;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (r_sh_full) begin
                    w_promote = 1'b1;
                end
            end

            ST_RUN: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (w_ch_hit[i]) begin
                        w_stb[i]      = 1'b1;
                        w_cnt_nxt[i]  = '0;
                        w_done_nxt[i] = r_done[i] + word_t'(1);
                    end else if (w_ch_act[i]) begin
                        w_cnt_nxt[i]  = r_cnt[i] + word_t'(1);
                    end
                end
                if (w_seg_end) begin
                    w_seg_done = 1'b1;
                    if (r_sh_full) begin
                        // Gapless hand-over: new counters start from 0 next cycle.
                        w_promote = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_wait_nxt  = '0;
                    end
                end
            end

            ST_WAIT: begin
                if (r_sh_full) begin
                    w_promote = 1'b1;
                end else if (reached(r_wait_cnt, w_adt) && !w_accept) begin
                    // Timeout: first abort pulse fires in this same cycle. A segment
                    // arriving on the timeout cycle holds off the abort instead; it
                    // is promoted on the next cycle.
                    w_abort     = 1'b1;
                    w_stb       = r_mask;
                    w_acnt_nxt  = '0;
                    w_state_nxt = ST_ABORT;
                    for (int i = 0; i < N_CH; i++) begin
                        w_done_nxt[i] = r_mask[i] ? word_t'(1) : '0;
                    end
                end else begin
                    w_wait_nxt = r_wait_cnt + word_t'(1);
                end
            end

            ST_ABORT: begin
                if (r_sh_full) begin
                    w_promote = 1'b1;
                end else if (reached(r_abort_cnt, w_adt)) begin
                    w_stb      = r_mask;
                    w_acnt_nxt = '0;
                    for (int i = 0; i < N_CH; i++) begin
                        if (r_mask[i] && (r_done[i] != '1)) begin
                            w_done_nxt[i] = r_done[i] + word_t'(1);
                        end
                    end
                end else begin
                    w_acnt_nxt = r_abort_cnt + word_t'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_promote) begin
            for (int i = 0; i < N_CH; i++) begin
                w_dt_nxt[i]    = r_sh_dt[i];
                w_steps_nxt[i] = r_sh_steps[i];
                w_cnt_nxt[i]   = '0;
                w_done_nxt[i]  = '0;
                w_mask_nxt[i]  = (r_sh_dt[i] != '0) && (r_sh_steps[i] != '0);
            end
            w_sh_full_nxt = 1'b0;
            w_state_nxt   = ST_RUN;
        end

        // Accept and promote are mutually exclusive: accept needs an empty shadow,
        // promote needs a full one.
        if (w_accept) begin
            w_sh_full_nxt = 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                w_sh_dt_nxt[i]    = seg_dt[i*W +: W];
                w_sh_steps_nxt[i] = seg_steps[i*W +: W];
            end
        end

        // stop (and reset) override everything, including pulses already due.
        if (stop || reset) begin
            w_stb         = '0;
            w_seg_done    = 1'b0;
            w_abort       = (r_state == ST_ABORT);
            w_state_nxt   = ST_IDLE;
            w_sh_full_nxt = 1'b0;
            w_wait_nxt    = '0;
            w_acnt_nxt    = '0;
            w_mask_nxt    = '0;
            for (int i = 0; i < N_CH; i++) begin
                w_cnt_nxt[i]   = '0;
                w_done_nxt[i]  = '0;
                w_dt_nxt[i]    = '0;
                w_steps_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sh_full   <= 1'b0;
            r_mask      <= '0;
            r_wait_cnt  <= '0;
            r_abort_cnt <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_sh_dt[i]    <= '0;
                r_sh_steps[i] <= '0;
                r_dt[i]       <= '0;
                r_steps[i]    <= '0;
                r_cnt[i]      <= '0;
                r_done[i]     <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_sh_full   <= w_sh_full_nxt;
            r_mask      <= w_mask_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_abort_cnt <= w_acnt_nxt;
            r_sh_dt     <= w_sh_dt_nxt;
            r_sh_steps  <= w_sh_steps_nxt;
            r_dt        <= w_dt_nxt;
            r_steps     <= w_steps_nxt;
            r_cnt       <= w_cnt_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        steps_done = '0;
        for (int i = 0; i < N_CH; i++) begin
            steps_done[i*W +: W] = r_done[i];
        end
    end

    assign seg_ready = !r_sh_full;
    assign step_stb  = w_stb;
    assign seg_done  = w_seg_done;
    assign busy      = (r_state != ST_IDLE);
    assign abort     = w_abort;

endmodule
